tnn_neuron_serial: RTL
======================

Name: tnn_neuron_serial

Overview:
- Sequential, parametrised successor to the combinational 5-input, 3-bit ternary neuron.
- Accepts one unsigned activation per beat over a valid/ready stream. Each beat is tagged as belonging to the positive-weight or the negative-weight group.
- Accumulates the signed difference (positive sum minus negative sum). At frame end it emits a 1-bit firing decision, diff > THRESH.
- Sits between the input-feature sequencer and the layer output collector. One instance is time-multiplexed per neuron instead of one wide combinational tree.

Parameters:
- IN_W, 3, activation width in bits (unsigned).
- N_IN, 5, maximum beats per frame (fan-in).
- THRESH, 0, signed firing threshold; fire when diff > THRESH.
- ACC_W, IN_W+$clog2(N_IN)+1, signed accumulator width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  IN_W  unsigned activation.
- in_neg  in  1  0 = add to diff, 1 = subtract from diff.
- in_last  in  1  final beat of frame.
- out_valid  out  1  decision valid.
- out_ready  in  1  downstream accepts decision.
- out_fire  out  1  1 when diff > THRESH.
- out_short  out  1  frame ended by in_last before N_IN beats.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=ACC, acc=0, cnt=0.
  - out_valid=0, out_fire=0, out_short=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-frame discards the partial frame. Reset while out_valid=1 drops the pending decision.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Input beat accepted when in_valid & in_ready:
  - acc <= acc ± zero-extended in_data.
  - cnt <= cnt+1.
- Frame end: the accepted beat has in_last=1, or cnt==N_IN-1 (the N_IN-th beat). On frame end:
  - state -> HOLD.
  - out_fire <= (acc_next > THRESH), signed compare including the current beat.
  - out_short <= in_last & (cnt != N_IN-1).
  - acc and cnt cleared.
- When the N_IN-th beat arrives with in_last=0, the frame ends anyway and out_short=0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- HOLD:
  - out_fire and out_short stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state -> ACC; in_ready=1 next cycle.
  - Throughput: at most one frame per N_IN+1 cycles.
- Arithmetic:
  - ACC_W is sized so that ±N_IN·(2^IN_W−1) never overflows.
  - No saturation. Tie (diff==THRESH) gives fire=0.
- in_valid=0 beats between accepted beats are allowed; acc and cnt hold.
- in_data, in_neg and in_last are ignored when not accepted.
- A single-beat frame (in_last on the first beat) is legal. out_short=1 unless N_IN==1.

Optional Feature:
- Macro TNN_DIFF_OUT_EN.
- Defined:
  - Adds output port out_diff [ACC_W-1:0], the signed two's-complement frame diff.
  - out_diff is registered with out_fire, valid under out_valid, and resets to 0.
- Undefined:
  - Port absent; no diff register (decision bit only).
  - All other behaviour identical.

Test Plan:
- Defaults, beats (3,+),(4,+),(2,−),(2,−),(2,−), no in_last -> one cycle after beat 5: out_valid=1, out_fire=1 (diff=1), out_short=0.
- Beats (3,+),(4,+),(2,−),(2,−),(3,−) -> out_fire=0 (diff=0, tie). With TNN_DIFF_OUT_EN: out_diff=0.
- Extremes: all five beats 7,+ -> out_fire=1, out_diff=35. All five beats 7,− -> out_fire=0, out_diff=−35 (0x5D in 7 bits). No overflow.
- Beats (5,+),(1,− with in_last) -> out_valid after beat 2, out_fire=1, out_short=1. Next frame starts clean: acc=0, cnt=0.
- Backpressure: hold out_ready=0 for 10 cycles after a frame -> in_ready=0, outputs stable throughout. On out_ready=1: out_valid drops next cycle, in_ready=1.
- Assert rst_n=0 after 3 beats, then a full frame of 1,+ ×5 -> out_fire=1, diff=5 (pre-reset beats discarded). in_valid gaps of 2 cycles between beats give an identical result.

Source files
------------

// File: rtl/tnn_neuron_serial.sv
// Serial ternary neuron: accumulates signed beat stream, emits fire decision.
// Optional out_diff port enabled by defining TNN_DIFF_OUT_EN.
module tnn_neuron_serial #(
  parameter int IN_W   = 3,
  parameter int N_IN   = 5,
  parameter int THRESH = 0,
  parameter int ACC_W  = IN_W + $clog2(N_IN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_neg,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_fire,
`ifdef TNN_DIFF_OUT_EN
  output logic            out_short,
  output logic [ACC_W-1:0] out_diff
`else
  output logic            out_short
`endif
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N_IN - 1);

  typedef enum logic {S_ACC, S_HOLD} state_e;

  state_e state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] acc_nx, beat_ext;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic fire_q, fire_d;
  logic short_q, short_d;
  logic accept, frame_end;
`ifdef TNN_DIFF_OUT_EN
  logic signed [ACC_W-1:0] diff_q, diff_d;
`endif

  // Beat arithmetic and frame-end detection.
  always_comb begin
    beat_ext  = $signed({{(ACC_W-IN_W){1'b0}}, in_data});
    acc_nx    = in_neg ? (acc_q - beat_ext) : (acc_q + beat_ext);
    accept    = in_valid & (state_q == S_ACC);
    frame_end = accept & (in_last | (cnt_q == CNT_MAX));
  end

  // Next-state logic: accumulate in ACC, hold decision in HOLD.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    fire_d  = fire_q;
    short_d = short_q;
`ifdef TNN_DIFF_OUT_EN
    diff_d  = diff_q;
`endif
    unique case (state_q)
      S_ACC: begin
        if (frame_end) begin
          state_d = S_HOLD;
          acc_d   = '0;
          cnt_d   = '0;
          fire_d  = (int'(acc_nx) > THRESH);
          short_d = in_last & (cnt_q != CNT_MAX);
`ifdef TNN_DIFF_OUT_EN
          diff_d  = acc_nx;
`endif
        end else if (accept) begin
          acc_d = acc_nx;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_ACC;
      end
      default: state_d = S_ACC;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      fire_q  <= 1'b0;
      short_q <= 1'b0;
`ifdef TNN_DIFF_OUT_EN
      diff_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      fire_q  <= fire_d;
      short_q <= short_d;
`ifdef TNN_DIFF_OUT_EN
      diff_q  <= diff_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_HOLD);
  assign out_fire  = fire_q;
  assign out_short = short_q;
`ifdef TNN_DIFF_OUT_EN
  assign out_diff  = diff_q;
`endif

endmodule
